hpdcache_cmo_issuer: RTL and testbench

Initiator side of the CMO handler request interface. It accepts one cache-management request (fence, or invalidate by line, set or all) from the core-side request path, registers it, and presents it to the CMO handler with a valid/ready handshake. It then tracks completion by watching the handler's ready signal, and returns an optional response to the requester. It sits between the core request arbiter and the CMO handler, and it allows only one CMO in flight.

---
 rtl/hpdcache_pkg.sv | 37 +++
 rtl/hpdcache_cmo_watchdog.sv | 37 +++
 rtl/hpdcache_cmo_issuer.sv | 168 ++++++++++++++++
 tb/tb_hpdcache_cmo_issuer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hpdcache_pkg.sv
// Shared HPDcache types for the CMO issuer: handler op encoding, timeout type,
// configuration structure and default request field types.
package hpdcache_pkg;

   typedef struct packed {
      logic is_fence;
      logic is_inval_by_nline;
      logic is_inval_by_set;
      logic is_inval_all;
   } hpdcache_cmoh_op_t;

   typedef logic [15:0] hpdcache_cmo_timeout_t;

   typedef struct packed {
      logic [7:0] reqWords;
      logic [7:0] reqWordWidth;
   } hpdcache_cfg_t;

   localparam int unsigned HPDCACHE_REQ_ADDR_WIDTH = 40;
   localparam int unsigned HPDCACHE_REQ_WORDS      = 2;
   localparam int unsigned HPDCACHE_REQ_WORD_WIDTH = 64;
   localparam int unsigned HPDCACHE_REQ_SID_WIDTH  = 3;
   localparam int unsigned HPDCACHE_REQ_TID_WIDTH  = 6;

   typedef logic [HPDCACHE_REQ_ADDR_WIDTH-1:0] hpdcache_req_addr_default_t;
   typedef logic [HPDCACHE_REQ_WORDS-1:0][HPDCACHE_REQ_WORD_WIDTH-1:0] hpdcache_req_data_default_t;
   typedef logic [HPDCACHE_REQ_SID_WIDTH-1:0] hpdcache_req_sid_default_t;
   typedef logic [HPDCACHE_REQ_TID_WIDTH-1:0] hpdcache_req_tid_default_t;

   // Exactly one operation bit may be set for the handler to accept the request.
   function automatic logic cmoh_op_is_onehot(input hpdcache_cmoh_op_t op);
      logic [3:0] v;
      v = op;
      return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
   endfunction

endpackage

// File: rtl/hpdcache_cmo_watchdog.sv
// Completion watchdog for the CMO issuer: counts WAIT_DONE cycles, saturates at
// the limit and keeps a sticky timeout flag. Used only with HPDCACHE_CMO_TIMEOUT_EN.
module hpdcache_cmo_watchdog
   import hpdcache_pkg::*;
#(
   parameter hpdcache_cmo_timeout_t cmoTimeoutCycles = 16'd1024
)(
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic active,
   output logic expire,
   output logic timeout
);

   hpdcache_cmo_timeout_t cnt;

   // expire pulses on the cycle whose increment makes the count reach the limit
   assign expire = active && (cnt != cmoTimeoutCycles) && ((cnt + 16'd1) == cmoTimeoutCycles);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= 16'd0;
         timeout <= 1'b0;
      end else begin
         if (start) begin
            cnt <= 16'd0;
         end else if (active && (cnt != cmoTimeoutCycles)) begin
            cnt <= cnt + 16'd1;
         end
         if (expire) begin
            timeout <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/hpdcache_cmo_issuer.sv
// Issues one cache-management operation at a time to the CMO handler and returns
// an optional response. Optional watchdog enabled by HPDCACHE_CMO_TIMEOUT_EN.
module hpdcache_cmo_issuer
   import hpdcache_pkg::*;
#(
   parameter hpdcache_cfg_t         hpdcacheCfg         = '0,
   parameter type                   hpdcache_req_addr_t = hpdcache_req_addr_default_t,
   parameter type                   hpdcache_req_data_t = hpdcache_req_data_default_t,
   parameter type                   hpdcache_req_sid_t  = hpdcache_req_sid_default_t,
   parameter type                   hpdcache_req_tid_t  = hpdcache_req_tid_default_t,
   parameter hpdcache_cmo_timeout_t cmoTimeoutCycles    = 16'd1024
)(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               core_req_valid_i,
   output logic               core_req_ready_o,
   input  hpdcache_cmoh_op_t  core_req_op_i,
   input  hpdcache_req_addr_t core_req_addr_i,
   input  hpdcache_req_data_t core_req_wdata_i,
   input  hpdcache_req_sid_t  core_req_sid_i,
   input  hpdcache_req_tid_t  core_req_tid_i,
   input  logic               core_req_need_rsp_i,
   output logic               core_rsp_valid_o,
   input  logic               core_rsp_ready_i,
   output hpdcache_req_sid_t  core_rsp_sid_o,
   output hpdcache_req_tid_t  core_rsp_tid_o,
   output logic               core_rsp_error_o,
   output logic               cmoh_req_valid_o,
   input  logic               cmoh_req_ready_i,
   output hpdcache_cmoh_op_t  cmoh_req_op_o,
   output hpdcache_req_addr_t cmoh_req_addr_o,
   output hpdcache_req_data_t cmoh_req_wdata_o,
   input  logic               cmoh_req_wait_i,
   output logic               busy_o,
   output logic               cmo_timeout_o
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESP} state_t;

   state_t             state;
   state_t             state_next;
   hpdcache_cmoh_op_t  op_q;
   hpdcache_req_addr_t addr_q;
   hpdcache_req_data_t wdata_q;
   hpdcache_req_sid_t  sid_q;
   hpdcache_req_tid_t  tid_q;
   logic               need_rsp_q;
   logic               err_q;
   logic               accept;
   logic               op_legal;
   logic               expire;
   logic               unused_inputs;

   assign accept   = (state == IDLE) && core_req_valid_i;
   assign op_legal = cmoh_op_is_onehot(core_req_op_i);

`ifdef HPDCACHE_CMO_TIMEOUT_EN
   hpdcache_cmo_watchdog #(
      .cmoTimeoutCycles (cmoTimeoutCycles)
   ) watchdog (
      .clk     (clk_i),
      .rst     (rst_i),
      .start   ((state == ISSUE) && cmoh_req_ready_i),
      .active  (state == WAIT_DONE),
      .expire  (expire),
      .timeout (cmo_timeout_o)
   );
   assign unused_inputs = ^{cmoh_req_wait_i, hpdcacheCfg};
`else
   assign expire        = 1'b0;
   assign cmo_timeout_o = 1'b0;
   assign unused_inputs = ^{cmoh_req_wait_i, hpdcacheCfg, cmoTimeoutCycles};
`endif

   // wait_i is informational only; completion is the handler returning to ready
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (core_req_valid_i) begin
               if (op_legal) begin
                  state_next = ISSUE;
               end else if (core_req_need_rsp_i) begin
                  state_next = RESP;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               state_next = IDLE;
            end
         end
         ISSUE: begin
            if (cmoh_req_ready_i) begin
               state_next = WAIT_DONE;
            end else begin
               state_next = ISSUE;
            end
         end
         WAIT_DONE: begin
            if (cmoh_req_ready_i) begin
               state_next = need_rsp_q ? RESP : IDLE;
            end else begin
               state_next = WAIT_DONE;
            end
         end
         RESP: begin
            if (core_rsp_ready_i) begin
               state_next = IDLE;
            end else begin
               state_next = RESP;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Request fields are captured only on acceptance so they stay stable while issued
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         op_q       <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         sid_q      <= '0;
         tid_q      <= '0;
         need_rsp_q <= 1'b0;
      end else if (accept) begin
         op_q       <= core_req_op_i;
         addr_q     <= core_req_addr_i;
         wdata_q    <= core_req_wdata_i;
         sid_q      <= core_req_sid_i;
         tid_q      <= core_req_tid_i;
         need_rsp_q <= core_req_need_rsp_i;
      end
   end

   // Error is re-evaluated on each new request, cleared by the response handshake
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_q <= 1'b0;
      end else if (accept) begin
         err_q <= !op_legal;
      end else if ((state == RESP) && core_rsp_ready_i) begin
         err_q <= 1'b0;
      end else if (expire) begin
         err_q <= 1'b1;
      end
   end

   assign core_req_ready_o = (state == IDLE);
   assign cmoh_req_valid_o = (state == ISSUE);
   assign core_rsp_valid_o = (state == RESP);
   assign busy_o           = (state != IDLE);
   assign cmoh_req_op_o    = op_q;
   assign cmoh_req_addr_o  = addr_q;
   assign cmoh_req_wdata_o = wdata_q;
   assign core_rsp_sid_o   = sid_q;
   assign core_rsp_tid_o   = tid_q;
   assign core_rsp_error_o = err_q;

endmodule

// File: tb/tb_hpdcache_cmo_issuer.sv
// Randomized scoreboard bench for hpdcache_cmo_issuer; honours HPDCACHE_CMO_TIMEOUT_EN.
module tb_hpdcache_cmo_issuer;
   import hpdcache_pkg::*;

   typedef hpdcache_req_addr_default_t addr_t;
   typedef hpdcache_req_data_default_t data_t;
   typedef hpdcache_req_sid_default_t  sid_t;
   typedef hpdcache_req_tid_default_t  tid_t;

   localparam int LIMIT = 8;
`ifdef HPDCACHE_CMO_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   typedef struct {
      logic [3:0] op;
      addr_t      addr;
      data_t      wdata;
   } cmoh_exp_t;

   typedef struct {
      sid_t s;
      tid_t t;
      logic err;
   } rsp_exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic core_req_valid = 1'b0;
   logic core_req_ready;
   hpdcache_cmoh_op_t core_req_op = '0;
   addr_t core_req_addr = '0;
   data_t core_req_wdata = '0;
   sid_t  core_req_sid = '0;
   tid_t  core_req_tid = '0;
   logic  core_req_need_rsp = 1'b0;
   logic  core_rsp_valid;
   logic  core_rsp_ready = 1'b0;
   sid_t  core_rsp_sid;
   tid_t  core_rsp_tid;
   logic  core_rsp_error;
   logic  cmoh_req_valid;
   logic  cmoh_req_ready = 1'b1;
   hpdcache_cmoh_op_t cmoh_req_op;
   addr_t cmoh_req_addr;
   data_t cmoh_req_wdata;
   logic  cmoh_req_wait = 1'b0;
   logic  busy;
   logic  cmo_timeout;

   int errors = 0;
   int checks = 0;
   cmoh_exp_t cmoh_q[$];
   rsp_exp_t  rsp_q[$];
   bit sticky_to = 1'b0;

   hpdcache_cmo_issuer #(
      .hpdcacheCfg      ('0),
      .cmoTimeoutCycles (16'(LIMIT))
   ) dut (
      .clk_i               (clk),
      .rst_i               (rst),
      .core_req_valid_i    (core_req_valid),
      .core_req_ready_o    (core_req_ready),
      .core_req_op_i       (core_req_op),
      .core_req_addr_i     (core_req_addr),
      .core_req_wdata_i    (core_req_wdata),
      .core_req_sid_i      (core_req_sid),
      .core_req_tid_i      (core_req_tid),
      .core_req_need_rsp_i (core_req_need_rsp),
      .core_rsp_valid_o    (core_rsp_valid),
      .core_rsp_ready_i    (core_rsp_ready),
      .core_rsp_sid_o      (core_rsp_sid),
      .core_rsp_tid_o      (core_rsp_tid),
      .core_rsp_error_o    (core_rsp_error),
      .cmoh_req_valid_o    (cmoh_req_valid),
      .cmoh_req_ready_i    (cmoh_req_ready),
      .cmoh_req_op_o       (cmoh_req_op),
      .cmoh_req_addr_o     (cmoh_req_addr),
      .cmoh_req_wdata_o    (cmoh_req_wdata),
      .cmoh_req_wait_i     (cmoh_req_wait),
      .busy_o              (busy),
      .cmo_timeout_o       (cmo_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard on every handshake and checks field stability
   logic pv = 1'b0;
   logic [3:0] p_op;
   addr_t p_addr;
   data_t p_wdata;
   always @(negedge clk) begin
      if (rst) begin
         pv = 1'b0;
      end else begin
         if (pv) begin
            chk("cmoh_op_stable", 128'(cmoh_req_op), 128'(p_op));
            chk("cmoh_addr_stable", 128'(cmoh_req_addr), 128'(p_addr));
            chk("cmoh_wdata_stable", 128'(cmoh_req_wdata), 128'(p_wdata));
            chk("cmoh_valid_kept", 128'(cmoh_req_valid), 128'(1));
         end
         if (cmoh_req_valid && cmoh_req_ready) begin
            if (cmoh_q.size() == 0) begin
               chk("cmoh_unexpected", 128'(1), 128'(0));
            end else begin
               cmoh_exp_t e;
               e = cmoh_q.pop_front();
               chk("cmoh_op", 128'(cmoh_req_op), 128'(e.op));
               chk("cmoh_addr", 128'(cmoh_req_addr), 128'(e.addr));
               chk("cmoh_wdata", 128'(cmoh_req_wdata), 128'(e.wdata));
            end
         end
         pv = cmoh_req_valid && !cmoh_req_ready;
         p_op = cmoh_req_op;
         p_addr = cmoh_req_addr;
         p_wdata = cmoh_req_wdata;
         if (core_rsp_valid && core_rsp_ready) begin
            if (rsp_q.size() == 0) begin
               chk("rsp_unexpected", 128'(1), 128'(0));
            end else begin
               rsp_exp_t r;
               r = rsp_q.pop_front();
               chk("rsp_sid", 128'(core_rsp_sid), 128'(r.s));
               chk("rsp_tid", 128'(core_rsp_tid), 128'(r.t));
               chk("rsp_error", 128'(core_rsp_error), 128'(r.err));
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One complete transaction; p = handler pre-accept stall, d = post-accept busy
   // cycles, r = response back-pressure cycles.
   task automatic run_txn(input logic [3:0] opv, input addr_t a, input data_t wd,
                          input sid_t s, input tid_t t, input logic need,
                          input int p, input int d, input int r);
      bit legal;
      bit err;
      legal = ($countones(opv) == 1);
      err = !legal || (TO_EN && legal && (d + 1 >= LIMIT));
      if (legal) cmoh_q.push_back('{opv, a, wd});
      if (need) rsp_q.push_back('{s, t, err});

      core_req_valid = 1'b1;
      core_req_op = hpdcache_cmoh_op_t'(opv);
      core_req_addr = a;
      core_req_wdata = wd;
      core_req_sid = s;
      core_req_tid = t;
      core_req_need_rsp = need;
      cmoh_req_ready = (p == 0);
      @(negedge clk);
      chk("req_ready_idle", 128'(core_req_ready), 128'(1));
      step();
      core_req_valid = 1'b0;
      core_req_addr = addr_t'({$urandom, $urandom});
      core_req_op = hpdcache_cmoh_op_t'(4'($urandom));

      if (legal) begin
         for (int i = 0; i < p; i++) begin
            @(negedge clk);
            chk("cmoh_valid_stall", 128'(cmoh_req_valid), 128'(1));
            step();
            if (i == p - 1) cmoh_req_ready = 1'b1;
         end
         @(negedge clk);
         chk("cmoh_valid", 128'(cmoh_req_valid), 128'(1));
         step();
         cmoh_req_ready = (d == 0);
         for (int i = 0; i <= d; i++) begin
            @(negedge clk);
            chk("wait_no_rsp", 128'(core_rsp_valid), 128'(0));
            chk("wait_busy", 128'(busy), 128'(1));
            chk("wait_no_cmoh", 128'(cmoh_req_valid), 128'(0));
            chk("wait_timeout", 128'(cmo_timeout), 128'(sticky_to || (TO_EN && i >= LIMIT)));
            step();
            if (i == d - 1) cmoh_req_ready = 1'b1;
         end
         if (TO_EN && (d + 1 >= LIMIT)) sticky_to = 1'b1;
      end

      if (need) begin
         core_rsp_ready = (r == 0);
         for (int i = 0; i < r; i++) begin
            @(negedge clk);
            chk("rsp_valid_held", 128'(core_rsp_valid), 128'(1));
            step();
            if (i == r - 1) core_rsp_ready = 1'b1;
         end
         @(negedge clk);
         chk("rsp_valid", 128'(core_rsp_valid), 128'(1));
         chk("no_req_during_rsp", 128'(core_req_ready), 128'(0));
         step();
         core_rsp_ready = 1'b0;
      end
      @(negedge clk);
      chk("back_to_idle", 128'(core_req_ready), 128'(1));
      chk("idle_not_busy", 128'(busy), 128'(0));
      chk("idle_no_rsp", 128'(core_rsp_valid), 128'(0));
      chk("timeout_sticky", 128'(cmo_timeout), 128'(sticky_to));
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL sim_time_limit: got expired expected completion");
      $fatal(1, "time limit");
   end

   initial begin
      data_t wd;
      logic [3:0] opv;
      step();
      @(negedge clk);
      chk("rst_req_ready", 128'(core_req_ready), 128'(1));
      chk("rst_cmoh_valid", 128'(cmoh_req_valid), 128'(0));
      chk("rst_rsp_valid", 128'(core_rsp_valid), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_timeout", 128'(cmo_timeout), 128'(0));
      chk("rst_rsp_error", 128'(core_rsp_error), 128'(0));
      chk("rst_cmoh_op", 128'(cmoh_req_op), 128'(0));
      step();
      rst = 1'b0;
      step();

      wd = '0;
      run_txn(4'b1000, addr_t'(40'h100), wd, sid_t'(3), tid_t'(5), 1'b1, 0, 0, 0);
      run_txn(4'b0001, addr_t'(40'h0), wd, sid_t'(1), tid_t'(2), 1'b1, 0, 64, 1);
      wd[0] = 64'h5;
      run_txn(4'b0010, addr_t'(40'h2c0), wd, sid_t'(6), tid_t'(9), 1'b1, 3, 0, 0);
      run_txn(4'b1100, addr_t'(40'h40), wd, sid_t'(2), tid_t'(7), 1'b1, 0, 0, 2);
      run_txn(4'b1100, addr_t'(40'h40), wd, sid_t'(2), tid_t'(8), 1'b0, 0, 0, 0);
      run_txn(4'b0100, addr_t'(40'h1234), wd, sid_t'(4), tid_t'(11), 1'b1, 1, 20, 0);

      for (int n = 0; n < 40; n++) begin
         opv = 4'(1 << $urandom_range(3, 0));
         if ($urandom_range(3, 0) == 0) opv = 4'($urandom);
         wd = {$urandom, $urandom, $urandom, $urandom};
         run_txn(opv, addr_t'({$urandom, $urandom}), wd, sid_t'($urandom), tid_t'($urandom),
                 1'($urandom), $urandom_range(4, 0), $urandom_range(12, 0), $urandom_range(3, 0));
      end

      // reset while the handler is still busy with an accepted CMO
      cmoh_q.push_back('{4'b0100, addr_t'(40'hbeef), wd});
      core_req_valid = 1'b1;
      core_req_op = hpdcache_cmoh_op_t'(4'b0100);
      core_req_addr = addr_t'(40'hbeef);
      core_req_wdata = wd;
      core_req_need_rsp = 1'b1;
      cmoh_req_ready = 1'b1;
      step();
      core_req_valid = 1'b0;
      step();
      cmoh_req_ready = 1'b0;
      step();
      step();
      @(negedge clk);
      chk("pre_rst_busy", 128'(busy), 128'(1));
      step();
      rst = 1'b1;
      sticky_to = 1'b0;
      @(negedge clk);
      chk("rst_mid_req_ready", 128'(core_req_ready), 128'(1));
      chk("rst_mid_busy", 128'(busy), 128'(0));
      step();
      rst = 1'b0;
      cmoh_req_ready = 1'b1;
      core_rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("post_rst_no_rsp", 128'(core_rsp_valid), 128'(0));
         chk("post_rst_idle", 128'(core_req_ready), 128'(1));
         step();
      end
      core_rsp_ready = 1'b0;
      run_txn(4'b1000, addr_t'(40'h8), wd, sid_t'(5), tid_t'(1), 1'b1, 0, 0, 0);

      chk("cmoh_q_drained", 128'(cmoh_q.size()), 128'(0));
      chk("rsp_q_drained", 128'(rsp_q.size()), 128'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
